hybrid_cache_line_ctrl: RTL and testbench

- Controller for an array of NLINES hybrid cache lines.
- Detects requester misses and picks a victim line: lowest hit counter among ready lines.
- Sequences the victim's fill, or flush-then-fill if dirty, and steers the shared memory port to the active line.
- Also executes a software-requested flush of all dirty lines. Sits between the dcache/icache front ends and the line array.

---
 rtl/hybrid_cache_line_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hybrid_cache_line_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_cache_line_ctrl.sv
// rtl/hybrid_cache_line_ctrl.sv - miss victim selection and fill/flush sequencing for a hybrid cache line array
module hybrid_cache_line_ctrl #(
  parameter int ADDRBITS   = 32,
  parameter int LSBBITS    = 7,
  parameter int MAXHITBITS = 8,
  parameter int NLINES     = 4,
  parameter int LINEBITS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRBITS-1:0]          dcache_rdaddr,
  input  logic                         dcache_rdreq,
  input  logic [ADDRBITS-1:0]          dcache_wraddr,
  input  logic                         dcache_wrreq,
  input  logic [ADDRBITS-1:0]          icache_rdaddr,
  input  logic                         icache_rdreq,
  input  logic [NLINES-1:0]            line_dcache_rdhit,
  input  logic [NLINES-1:0]            line_dcache_wrhit,
  input  logic [NLINES-1:0]            line_icache_rdhit,
  input  logic [NLINES*MAXHITBITS-1:0] line_hitcnt,
  input  logic [NLINES-1:0]            line_dirty,
  input  logic [NLINES-1:0]            line_ready,
  output logic [NLINES-1:0]            line_flush,
  output logic [NLINES-1:0]            line_fill,
  output logic [ADDRBITS-1:0]          line_new_region,
  output logic [LINEBITS-1:0]          mem_sel,
  output logic                         mem_sel_valid,
  input  logic                         flush_all_req,
  output logic                         flush_all_done,
  output logic                         ctrl_busy
);

  typedef enum logic [2:0] {
    IDLE, SELECT, ISSUE, WAIT_DROP, WAIT_READY, FA_SCAN, FA_ISSUE, FA_WAIT
  } state_t;

  state_t              state;
  logic [LINEBITS-1:0] scan_idx;
  logic [1:0]          wait_cnt;
  logic                dropped;
  logic                settle;

  logic                dmiss_rd, dmiss_wr, imiss;
  logic [ADDRBITS-1:0] miss_addr;
  logic [LINEBITS-1:0] victim;
  logic                victim_found;
  logic [MAXHITBITS-1:0] best_cnt;
  logic [NLINES-1:0]   sel_onehot, scan_onehot;
  logic                scan_last, fa_wait_done, fa_next;

  assign dmiss_rd = dcache_rdreq & ~|line_dcache_rdhit;
  assign dmiss_wr = dcache_wrreq & ~|line_dcache_wrhit;
  assign imiss    = icache_rdreq & ~|line_icache_rdhit;

  always_comb begin
    miss_addr = icache_rdaddr;
    if (dmiss_rd)      miss_addr = dcache_rdaddr;
    else if (dmiss_wr) miss_addr = dcache_wraddr;
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    best_cnt     = '0;
    for (int i = 0; i < NLINES; i++) begin
      if (line_ready[i] &&
          (!victim_found || line_hitcnt[i*MAXHITBITS +: MAXHITBITS] < best_cnt)) begin
        victim       = LINEBITS'(i);
        victim_found = 1'b1;
        best_cnt     = line_hitcnt[i*MAXHITBITS +: MAXHITBITS];
      end
    end
  end

  assign sel_onehot   = {{(NLINES-1){1'b0}}, 1'b1} << mem_sel;
  assign scan_onehot  = {{(NLINES-1){1'b0}}, 1'b1} << scan_idx;
  assign scan_last    = (scan_idx == LINEBITS'(NLINES-1));
  // A scanned line is finished once it rose again, or it never dropped within the window.
  assign fa_wait_done = (state == FA_WAIT) &&
                        (dropped ? line_ready[scan_idx]
                                 : (line_ready[scan_idx] && wait_cnt == 2'd3));
  assign fa_next      = ((state == FA_SCAN) && !line_dirty[scan_idx]) || fa_wait_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      scan_idx        <= '0;
      wait_cnt        <= '0;
      dropped         <= 1'b0;
      settle          <= 1'b0;
      line_flush      <= '0;
      line_fill       <= '0;
      line_new_region <= '0;
      mem_sel         <= '0;
      mem_sel_valid   <= 1'b0;
      flush_all_done  <= 1'b0;
      ctrl_busy       <= 1'b0;
    end else begin
      line_flush     <= '0;
      line_fill      <= '0;
      flush_all_done <= 1'b0;
      case (state)
        IDLE: begin
          // Hit vectors lag a completed fill by a cycle, so skip one evaluation.
          if (settle) begin
            settle <= 1'b0;
          end else if (flush_all_req) begin
            scan_idx  <= '0;
            state     <= FA_SCAN;
            ctrl_busy <= 1'b1;
          end else if (dmiss_rd || dmiss_wr || imiss) begin
            line_new_region <= {miss_addr[ADDRBITS-1:LSBBITS], {LSBBITS{1'b0}}};
            state           <= SELECT;
            ctrl_busy       <= 1'b1;
          end
        end
        SELECT: begin
          if (victim_found) begin
            mem_sel <= victim;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          line_fill     <= sel_onehot;
          line_flush    <= line_dirty[mem_sel] ? sel_onehot : '0;
          mem_sel_valid <= 1'b1;
          wait_cnt      <= '0;
          state         <= WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!line_ready[mem_sel]) begin
            state <= WAIT_READY;
          end else if (wait_cnt == 2'd3) begin
            mem_sel_valid <= 1'b0;
            ctrl_busy     <= 1'b0;
            settle        <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        WAIT_READY: begin
          if (line_ready[mem_sel]) begin
            mem_sel_valid <= 1'b0;
            ctrl_busy     <= 1'b0;
            settle        <= 1'b1;
            state         <= IDLE;
          end
        end
        FA_SCAN: begin
          if (line_dirty[scan_idx] && line_ready[scan_idx]) state <= FA_ISSUE;
        end
        FA_ISSUE: begin
          line_flush    <= scan_onehot;
          mem_sel       <= scan_idx;
          mem_sel_valid <= 1'b1;
          wait_cnt      <= '0;
          dropped       <= 1'b0;
          state         <= FA_WAIT;
        end
        FA_WAIT: begin
          if (fa_wait_done)               mem_sel_valid <= 1'b0;
          else if (!dropped && !line_ready[scan_idx]) dropped <= 1'b1;
          else if (!dropped)              wait_cnt <= wait_cnt + 2'd1;
        end
        default: state <= IDLE;
      endcase
      if (fa_next) begin
        if (scan_last) begin
          flush_all_done <= 1'b1;
          ctrl_busy      <= 1'b0;
          settle         <= 1'b1;
          state          <= IDLE;
        end else begin
          scan_idx <= scan_idx + LINEBITS'(1);
          state    <= FA_SCAN;
        end
      end
    end
  end

endmodule

// File: tb/tb_hybrid_cache_line_ctrl.sv
// tb/tb_hybrid_cache_line_ctrl.sv - randomized self-checking bench with a behavioural line array model
module tb_hybrid_cache_line_ctrl;
  localparam int AB = 32, LB = 7, HB = 8, NL = 4, IB = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [AB-1:0] dcache_rdaddr = '0, dcache_wraddr = '0, icache_rdaddr = '0;
  logic dcache_rdreq = 1'b0, dcache_wrreq = 1'b0, icache_rdreq = 1'b0;
  logic [NL-1:0] line_dcache_rdhit = '0, line_dcache_wrhit = '0, line_icache_rdhit = '0;
  logic [NL*HB-1:0] line_hitcnt = '0;
  logic [NL-1:0] line_dirty = '0, line_ready = '1;
  logic flush_all_req = 1'b0;
  logic [NL-1:0] line_flush, line_fill;
  logic [AB-1:0] line_new_region;
  logic [IB-1:0] mem_sel;
  logic mem_sel_valid, flush_all_done, ctrl_busy;

  hybrid_cache_line_ctrl #(.ADDRBITS(AB), .LSBBITS(LB), .MAXHITBITS(HB), .NLINES(NL), .LINEBITS(IB)) dut (
    .clk(clk), .reset(reset),
    .dcache_rdaddr(dcache_rdaddr), .dcache_rdreq(dcache_rdreq),
    .dcache_wraddr(dcache_wraddr), .dcache_wrreq(dcache_wrreq),
    .icache_rdaddr(icache_rdaddr), .icache_rdreq(icache_rdreq),
    .line_dcache_rdhit(line_dcache_rdhit), .line_dcache_wrhit(line_dcache_wrhit),
    .line_icache_rdhit(line_icache_rdhit), .line_hitcnt(line_hitcnt),
    .line_dirty(line_dirty), .line_ready(line_ready),
    .line_flush(line_flush), .line_fill(line_fill), .line_new_region(line_new_region),
    .mem_sel(mem_sel), .mem_sel_valid(mem_sel_valid),
    .flush_all_req(flush_all_req), .flush_all_done(flush_all_done), .ctrl_busy(ctrl_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int fill_cnt[NL], flush_cnt[NL], busy[NL];
  bit ignore_strobe[NL];
  int fill_tot, flush_tot, done_cnt, multi_cnt, pair_cnt, valid_err, busy_len;
  int flush_order[$];
  logic [IB-1:0] strobe_sel;
  logic strobe_valid;
  logic [AB-1:0] strobe_region;

  task automatic clear_log();
    for (int i = 0; i < NL; i++) begin fill_cnt[i] = 0; flush_cnt[i] = 0; end
    fill_tot = 0; flush_tot = 0; done_cnt = 0; multi_cnt = 0; pair_cnt = 0; valid_err = 0;
    flush_order.delete();
    strobe_sel = '0; strobe_valid = 1'b0; strobe_region = '0;
  endtask

  task automatic set_hitcnt(input int a, input int b, input int c, input int d);
    line_hitcnt = {d[HB-1:0], c[HB-1:0], b[HB-1:0], a[HB-1:0]};
  endtask

  // One clock: observe the outputs, then advance the line array model.
  task automatic step();
    @(negedge clk);
    if ($countones(line_fill) > 1 || $countones(line_flush) > 1) multi_cnt++;
    if (mem_sel_valid !== 1'b1 && ctrl_busy && !line_ready[mem_sel] && fill_tot + flush_tot > 0) valid_err++;
    if (line_fill != '0 || line_flush != '0) begin
      strobe_sel = mem_sel; strobe_valid = mem_sel_valid; strobe_region = line_new_region;
    end
    if (flush_all_done) done_cnt++;
    for (int i = 0; i < NL; i++) begin
      if (line_fill[i]) begin fill_cnt[i]++; fill_tot++; end
      if (line_flush[i]) begin flush_cnt[i]++; flush_tot++; flush_order.push_back(i); end
      if (line_fill[i] && line_flush[i]) pair_cnt++;
      if ((line_fill[i] || line_flush[i]) && !ignore_strobe[i]) begin
        line_ready[i] = 1'b0;
        busy[i] = (busy_len > 0) ? busy_len : int'($urandom_range(1, 3));
      end else if (busy[i] > 0) begin
        busy[i]--;
        if (busy[i] == 0) begin line_ready[i] = 1'b1; line_dirty[i] = 1'b0; end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (ctrl_busy && n < 300) begin step(); n++; end
    checks++;
    if (ctrl_busy !== 1'b0) begin
      failures++; $display("FAIL %s_timeout: ctrl_busy=%b required 0", name, ctrl_busy);
    end
    step(); step();
  endtask

  task automatic issue(input logic rd, input logic wr, input logic ir,
                       input logic [AB-1:0] ra, input logic [AB-1:0] wa, input logic [AB-1:0] ia,
                       input logic [NL-1:0] rh, input logic [NL-1:0] wh, input logic [NL-1:0] ih);
    dcache_rdreq = rd; dcache_wrreq = wr; icache_rdreq = ir;
    dcache_rdaddr = ra; dcache_wraddr = wa; icache_rdaddr = ia;
    line_dcache_rdhit = rh; line_dcache_wrhit = wh; line_icache_rdhit = ih;
    step();
    dcache_rdreq = 1'b0; dcache_wrreq = 1'b0; icache_rdreq = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({line_fill, line_flush, line_new_region, mem_sel, mem_sel_valid, flush_all_done, ctrl_busy} !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h required 0",
        {line_fill, line_flush, line_new_region, mem_sel, mem_sel_valid, flush_all_done, ctrl_busy});
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if (ctrl_busy !== 1'b0 || mem_sel_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: busy=%b valid=%b required 0 0", ctrl_busy, mem_sel_valid);
    end
  endtask

  task automatic test_basic_fill();
    clear_log();
    set_hitcnt(5, 6, 0, 9); line_dirty = '0; line_ready = '1;
    issue(1, 0, 0, 32'h0000_1234, 0, 0, '0, '0, '0);
    wait_idle("basic");
    checks++; if (fill_cnt[2] !== 1 || fill_tot !== 1) begin
      failures++; $display("FAIL basic_fill: fill2=%0d total=%0d required 1 1", fill_cnt[2], fill_tot); end
    checks++; if (flush_tot !== 0) begin
      failures++; $display("FAIL basic_noflush: flushes=%0d required 0", flush_tot); end
    checks++; if (strobe_region !== 32'h0000_1200 || strobe_sel !== 2'd2 || strobe_valid !== 1'b1) begin
      failures++; $display("FAIL basic_region: region=%h sel=%0d valid=%b required 00001200 2 1",
                           strobe_region, strobe_sel, strobe_valid); end
    checks++; if (valid_err !== 0 || mem_sel_valid !== 1'b0) begin
      failures++; $display("FAIL basic_valid_hold: drops=%0d final=%b required 0 0", valid_err, mem_sel_valid); end
  endtask

  task automatic test_dirty_dual_miss();
    clear_log();
    set_hitcnt(3, 1, 4, 2); line_dirty = 4'b0010; line_ready = '1;
    issue(1, 0, 1, 32'h0000_5A7F, 0, 32'h0000_9900, '0, '0, '0);
    wait_idle("dirty");
    checks++; if (pair_cnt !== 1 || fill_cnt[1] !== 1 || flush_cnt[1] !== 1 || fill_tot + flush_tot !== 2) begin
      failures++; $display("FAIL dirty_pair: pair=%0d fill1=%0d flush1=%0d required 1 1 1",
                           pair_cnt, fill_cnt[1], flush_cnt[1]); end
    checks++; if (strobe_region !== 32'h0000_5A00) begin
      failures++; $display("FAIL dirty_region: got %h required 00005a00", strobe_region); end
  endtask

  task automatic test_tie_and_stall();
    clear_log();
    set_hitcnt(0, 4, 7, 0); line_dirty = '0; line_ready = 4'b1110;
    issue(0, 1, 0, 0, 32'h0001_0080, 0, '0, '0, '0);
    wait_idle("tie");
    checks++; if (fill_cnt[3] !== 1 || fill_tot !== 1) begin
      failures++; $display("FAIL tie_victim: fill3=%0d total=%0d required 1 1", fill_cnt[3], fill_tot); end
    clear_log();
    line_ready = '0;
    issue(0, 0, 1, 0, 0, 32'h0002_0000, '0, '0, '0);
    for (int i = 0; i < 10; i++) step();
    checks++; if (fill_tot + flush_tot !== 0 || ctrl_busy !== 1'b1) begin
      failures++; $display("FAIL stall_select: strobes=%0d busy=%b required 0 1", fill_tot + flush_tot, ctrl_busy); end
    line_ready = 4'b0100;
    wait_idle("stall");
    checks++; if (fill_cnt[2] !== 1 || fill_tot !== 1) begin
      failures++; $display("FAIL stall_release: fill2=%0d total=%0d required 1 1", fill_cnt[2], fill_tot); end
    line_ready = '1;
  endtask

  task automatic test_flush_all();
    clear_log();
    line_dirty = 4'b1010; line_ready = '1;
    flush_all_req = 1'b1; step(); flush_all_req = 1'b0;
    wait_idle("flush_all");
    checks++; if (flush_order.size() !== 2 || flush_cnt[1] !== 1 || flush_cnt[3] !== 1) begin
      failures++; $display("FAIL fa_flushes: count=%0d f1=%0d f3=%0d required 2 1 1",
                           flush_order.size(), flush_cnt[1], flush_cnt[3]); end
    else begin
      checks++; if (flush_order[0] !== 1 || flush_order[1] !== 3) begin
        failures++; $display("FAIL fa_order: got %0d,%0d required 1,3", flush_order[0], flush_order[1]); end
    end
    checks++; if (done_cnt !== 1 || fill_tot !== 0 || multi_cnt !== 0) begin
      failures++; $display("FAIL fa_done: done=%0d fills=%0d multi=%0d required 1 0 0", done_cnt, fill_tot, multi_cnt); end
  endtask

  task automatic test_drop_timeout();
    int n = 0;
    int cnt = 0;
    clear_log();
    set_hitcnt(0, 3, 3, 3); line_dirty = '0; line_ready = '1; ignore_strobe[0] = 1'b1;
    issue(1, 0, 0, 32'h0000_4000, 0, 0, '0, '0, '0);
    while (fill_tot == 0 && n < 20) begin step(); n++; end
    while (ctrl_busy && cnt < 20) begin cnt++; step(); end
    checks++; if (cnt !== 4 || fill_cnt[0] !== 1) begin
      failures++; $display("FAIL drop_timeout: busy_cycles=%0d fill0=%0d required 4 1", cnt, fill_cnt[0]); end
    checks++; if (mem_sel_valid !== 1'b0) begin
      failures++; $display("FAIL drop_valid: got %b required 0", mem_sel_valid); end
    ignore_strobe[0] = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    busy_len = 8;
    set_hitcnt(2, 1, 6, 6); line_dirty = '0; line_ready = '1;
    issue(1, 0, 0, 32'h0000_7700, 0, 0, '0, '0, '0);
    while (fill_tot == 0 && n < 20) begin step(); n++; end
    step();
    checks++; if (ctrl_busy !== 1'b1 || mem_sel_valid !== 1'b1 || line_ready[1] !== 1'b0) begin
      failures++; $display("FAIL mid_precond: busy=%b valid=%b ready1=%b required 1 1 0",
                           ctrl_busy, mem_sel_valid, line_ready[1]); end
    reset = 1'b1;
    step();
    checks++;
    if ({line_fill, line_flush, line_new_region, mem_sel, mem_sel_valid, flush_all_done, ctrl_busy} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: got %h required 0",
        {line_fill, line_flush, line_new_region, mem_sel, mem_sel_valid, flush_all_done, ctrl_busy});
    end
    reset = 1'b0; busy_len = 0;
    n = 0;
    while (line_ready !== '1 && n < 30) begin step(); n++; end
    clear_log();
    set_hitcnt(4, 4, 1, 4);
    issue(0, 0, 1, 0, 0, 32'h0003_00FF, '0, '0, '0);
    wait_idle("restart");
    checks++; if (fill_cnt[2] !== 1 || fill_tot !== 1 || strobe_region !== 32'h0003_0080) begin
      failures++; $display("FAIL restart_fill: fill2=%0d total=%0d region=%h required 1 1 00030080",
                           fill_cnt[2], fill_tot, strobe_region); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int hc[NL];
      int mn, exp_v;
      logic [NL-1:0] rdy, dty, rh, wh, ih;
      logic rd, wr, ir;
      logic [AB-1:0] ra, wa, ia, exp_region;
      for (int i = 0; i < NL; i++) begin hc[i] = $urandom_range(0, 5); busy[i] = 0; end
      rdy = NL'($urandom); if (rdy == '0) rdy = 4'b0001 << $urandom_range(0, 3);
      dty = NL'($urandom);
      rd = 1'($urandom); wr = 1'($urandom); ir = 1'($urandom);
      rh = $urandom_range(0, 1) ? 4'b0001 << $urandom_range(0, 3) : 4'b0000;
      wh = $urandom_range(0, 1) ? 4'b0001 << $urandom_range(0, 3) : 4'b0000;
      ih = $urandom_range(0, 1) ? 4'b0001 << $urandom_range(0, 3) : 4'b0000;
      ra = $urandom; wa = $urandom; ia = $urandom;
      set_hitcnt(hc[0], hc[1], hc[2], hc[3]); line_ready = rdy; line_dirty = dty;
      mn = 1 << HB;
      for (int i = 0; i < NL; i++) if (rdy[i] && hc[i] < mn) mn = hc[i];
      exp_v = -1;
      for (int i = NL - 1; i >= 0; i--) if (rdy[i] && hc[i] == mn) exp_v = i;
      if (rd && rh == 0)      exp_region = ra & ~((32'h1 << LB) - 1);
      else if (wr && wh == 0) exp_region = wa & ~((32'h1 << LB) - 1);
      else                    exp_region = ia & ~((32'h1 << LB) - 1);
      clear_log();
      issue(rd, wr, ir, ra, wa, ia, rh, wh, ih);
      if ((rd && rh == 0) || (wr && wh == 0) || (ir && ih == 0)) begin
        wait_idle("random");
        checks++;
        if (fill_cnt[exp_v] !== 1 || fill_tot !== 1 || flush_tot !== int'(dty[exp_v]) ||
            strobe_sel !== IB'(exp_v) || strobe_region !== exp_region || multi_cnt !== 0) begin
          failures++;
          $display("FAIL random_%0d: fills=%0d flushes=%0d sel=%0d region=%h required victim=%0d flushes=%0d region=%h",
                   it, fill_tot, flush_tot, strobe_sel, strobe_region, exp_v, dty[exp_v], exp_region);
        end
      end else begin
        step(); step(); step();
        checks++;
        if (ctrl_busy !== 1'b0 || fill_tot + flush_tot !== 0) begin
          failures++; $display("FAIL random_nomiss_%0d: busy=%b strobes=%0d required 0 0",
                               it, ctrl_busy, fill_tot + flush_tot);
        end
      end
      line_ready = '1;
    end
  endtask

  initial begin
    busy_len = 0;
    for (int i = 0; i < NL; i++) begin busy[i] = 0; ignore_strobe[i] = 1'b0; end
    clear_log();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_fill();
    test_dirty_dual_miss();
    test_tie_and_stall();
    test_flush_all();
    test_drop_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
